// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-transmitter signal bundle for uart_tx_arbiter.
// The master side drives requests and the transmitter status; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_ReqValid;
    logic [8*N_REQ-1:0] i_ReqByte;
    logic [N_REQ-1:0]   i_ReqLast;
    logic [N_REQ-1:0]   o_ReqReady;
    logic               o_TxValid;
    logic [7:0]         o_TxByte;
    logic               i_TxDone;
    logic [N_REQ-1:0]   o_Grant;
    logic               o_Busy;
    logic               o_Error;

    modport master (
        output i_ReqValid, i_ReqByte, i_ReqLast, i_TxDone,
        input  o_ReqReady, o_TxValid, o_TxByte, o_Grant, o_Busy, o_Error
    );

    modport slave (
        input  i_ReqValid, i_ReqByte, i_ReqLast, i_TxDone,
        output o_ReqReady, o_TxValid, o_TxByte, o_Grant, o_Busy, o_Error
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// It locks onto a port for multi-byte packets and abandons a byte if the transmitter never starts.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_SysClock,
    input  logic            i_ResetN,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               error_q, error_d;
    logic               lock_q, lock_d;
    logic [IW-1:0]      lock_idx_q, lock_idx_d;
    logic [IW-1:0]      last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               found;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      rr_idx;
    logic [7:0]         sel_byte;
    logic [N_REQ-1:0]   sel_oh;

    // A held lock restricts the candidate set to the locked port only.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = '0;
        if (lock_q) begin
            found = bus.i_ReqValid[lock_idx_q];
            sel   = lock_idx_q;
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                rr_idx = IW'((int'(last_q) + i) % N_REQ);
                if (!found && bus.i_ReqValid[rr_idx]) begin
                    found = 1'b1;
                    sel   = rr_idx;
                end
            end
        end
    end

    assign sel_byte = bus.i_ReqByte[{sel, 3'b000} +: 8];
    assign sel_oh   = N_REQ'(1) << sel;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        ready_d    = '0;
        grant_d    = grant_q;
        error_d    = 1'b0;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = WAIT_START;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = sel_byte;
                    ready_d    = sel_oh;
                    grant_d    = sel_oh;
                    last_d     = sel;
                    cnt_d      = '0;
                    lock_d     = !bus.i_ReqLast[sel];
                    lock_idx_d = sel;
                end
            end
            WAIT_START: begin
                if (!bus.i_TxDone) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    error_d    = 1'b1;
                    tx_valid_d = 1'b0;
                    lock_d     = 1'b0;
                    grant_d    = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (bus.i_TxDone) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            ready_q    <= '0;
            grant_q    <= '0;
            error_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            last_q     <= IW'(N_REQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            ready_q    <= ready_d;
            grant_q    <= grant_d;
            error_q    <= error_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_ReqReady = ready_q;
    assign bus.o_TxValid  = tx_valid_q;
    assign bus.o_TxByte   = tx_byte_q;
    assign bus.o_Grant    = grant_q;
    assign bus.o_Busy     = (state_q != IDLE);
    assign bus.o_Error    = error_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte streams, a scripted
// transmitter, and a grant-order scoreboard.
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] pdata[4][8];
    int         phead[4];
    int         pcnt[4];

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();

    uart_tx_arbiter #(
        .N_REQ  (4),
        .TIMEOUT(8)
    ) dut (
        .i_SysClock(clk),
        .i_ResetN  (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            if (phead[k] < pcnt[k]) begin
                bus.i_ReqValid[k]         = 1'b1;
                bus.i_ReqLast[k]          = pdata[k][phead[k]][8];
                bus.i_ReqByte[8*k +: 8]   = pdata[k][phead[k]][7:0];
            end else begin
                bus.i_ReqValid[k]         = 1'b0;
                bus.i_ReqLast[k]          = 1'b0;
                bus.i_ReqByte[8*k +: 8]   = 8'h00;
            end
        end
    endtask

    task automatic load(input int k, input logic [7:0] b, input logic last);
        pdata[k][pcnt[k]] = {last, b};
        pcnt[k]++;
        apply();
    endtask

    // Requester model: advance a port's stream when it sees its accept pulse.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++)
            if (bus.o_ReqReady[k] && phead[k] < pcnt[k]) phead[k]++;
        apply();
    endtask

    task automatic wait_start(input string tag, output exp_t e);
        int n;
        n = 0;
        while (bus.o_TxValid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(bus.o_TxValid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{port: 0, data: 8'h00};
        chk({tag, "_grant"}, 32'(bus.o_Grant), 32'(4'b0001 << e.port));
        chk({tag, "_byte"}, 32'(bus.o_TxByte), 32'(e.data));
        chk({tag, "_ready"}, 32'(bus.o_ReqReady), 32'(4'b0001 << e.port));
        chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd1);
    endtask

    task automatic do_xfer(input string tag);
        exp_t e;
        wait_start(tag, e);
        tick();
        chk({tag, "_ready_drop"}, 32'(bus.o_ReqReady), 32'd0);
        chk({tag, "_txv_hold"}, 32'(bus.o_TxValid), 32'd1);
        bus.i_TxDone = 1'b0;
        tick();
        chk({tag, "_txv_drop"}, 32'(bus.o_TxValid), 32'd0);
        chk({tag, "_grant_hold"}, 32'(bus.o_Grant), 32'(4'b0001 << e.port));
        bus.i_TxDone = 1'b1;
        tick();
        chk({tag, "_idle"}, 32'(bus.o_Busy), 32'd0);
        chk({tag, "_grant_clr"}, 32'(bus.o_Grant), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_txv"}, 32'(bus.o_TxValid), 32'd0);
        chk({tag, "_byte"}, 32'(bus.o_TxByte), 32'd0);
        chk({tag, "_ready"}, 32'(bus.o_ReqReady), 32'd0);
        chk({tag, "_grant"}, 32'(bus.o_Grant), 32'd0);
        chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.o_Error), 32'd0);
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int k = 0; k < 4; k++) begin
            phead[k] = 0;
            pcnt[k]  = 0;
        end
        bus.i_TxDone = 1'b1;
        apply();
        rst_n = 1'b0;

        @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        load(2, 8'hA5, 1'b1);
        exp_q.push_back('{port: 2, data: 8'hA5});
        do_xfer("single");
        tick();
        chk("byte_hold", 32'(bus.o_TxByte), 32'hA5);

        rst_n = 1'b0;
        tick();
        chk("rst2_byte", 32'(bus.o_TxByte), 32'h00);
        rst_n = 1'b1;

        load(0, 8'h01, 1'b1);
        load(0, 8'h02, 1'b1);
        load(1, 8'h11, 1'b1);
        load(2, 8'h21, 1'b1);
        load(3, 8'h31, 1'b1);
        exp_q.push_back('{port: 0, data: 8'h01});
        exp_q.push_back('{port: 1, data: 8'h11});
        exp_q.push_back('{port: 2, data: 8'h21});
        exp_q.push_back('{port: 3, data: 8'h31});
        exp_q.push_back('{port: 0, data: 8'h02});
        for (int i = 0; i < 5; i++) do_xfer($sformatf("rr%0d", i));

        load(0, 8'h50, 1'b1);
        load(1, 8'h41, 1'b0);
        load(1, 8'h42, 1'b0);
        load(1, 8'h43, 1'b1);
        exp_q.push_back('{port: 1, data: 8'h41});
        exp_q.push_back('{port: 1, data: 8'h42});
        exp_q.push_back('{port: 1, data: 8'h43});
        exp_q.push_back('{port: 0, data: 8'h50});
        for (int i = 0; i < 4; i++) do_xfer($sformatf("lock%0d", i));

        load(1, 8'h3C, 1'b0);
        exp_q.push_back('{port: 1, data: 8'h3C});
        wait_start("to", e);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("to_noerr%0d", i), 32'(bus.o_Error), 32'd0);
        end
        tick();
        chk("to_err", 32'(bus.o_Error), 32'd1);
        chk("to_txv", 32'(bus.o_TxValid), 32'd0);
        chk("to_busy", 32'(bus.o_Busy), 32'd0);
        chk("to_grant", 32'(bus.o_Grant), 32'd0);
        tick();
        chk("to_err_pulse", 32'(bus.o_Error), 32'd0);

        load(0, 8'h77, 1'b1);
        exp_q.push_back('{port: 0, data: 8'h77});
        do_xfer("unlock");

        load(2, 8'h99, 1'b0);
        exp_q.push_back('{port: 2, data: 8'h99});
        wait_start("wd", e);
        bus.i_TxDone = 1'b0;
        tick();
        chk("wd_busy", 32'(bus.o_Busy), 32'd1);
        chk("wd_txv", 32'(bus.o_TxValid), 32'd0);
        load(3, 8'hC3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wd");
        bus.i_TxDone = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rel_ready", 32'(bus.o_ReqReady), 32'd0);
        exp_q.push_back('{port: 3, data: 8'hC3});
        do_xfer("post_rst");
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_REQ, 4, number of requester ports (2..8).
- TIMEOUT, 1023, cycles to wait for the transmitter to start before abandoning a byte.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_SysClock, in, 1, system clock, rising edge.
- i_ResetN, in, 1, asynchronous active-low reset.
- i_ReqValid, in, N_REQ, per-port byte-available.
- i_ReqByte, in, 8*N_REQ, per-port byte; port k occupies bits [8k+7:8k].
- i_ReqLast, in, N_REQ, per-port end-of-packet flag qualifying i_ReqByte.
- o_ReqReady, out, N_REQ, one-cycle accept pulse per port.
- o_TxValid, out, 1, start request to the UART transmitter.
- o_TxByte, out, 8, byte to the UART transmitter.
- i_TxDone, in, 1, transmitter idle/stop-bit indicator (high = may accept).
- o_Grant, out, N_REQ, one-hot current owner.
- o_Busy, out, 1, transfer in progress.
- o_Error, out, 1, one-cycle timeout pulse.
REQ-003 Reset i_ResetN SHALL be asynchronous, active-low; clock i_SysClock; all state SHALL update on rising i_SysClock only.

Function
REQ-004 FSM states SHALL be IDLE, WAIT_START, WAIT_DONE; o_Busy SHALL be 1 exactly when state != IDLE.
REQ-005 In IDLE with any i_ReqValid bit set, the block SHALL select grant index g at that edge, load o_TxByte from port g, set o_TxValid=1 and o_Grant=onehot(g), and go to WAIT_START.
REQ-006 o_ReqReady[g] SHALL be high for exactly the one cycle after the grant edge; other o_ReqReady bits SHALL be 0.
REQ-007 The requester SHALL hold i_ReqValid, i_ReqByte and i_ReqLast stable until it sees o_ReqReady; the byte is transferred at the grant edge.
REQ-008 Selection SHALL be round-robin: search starts at (last_grant+1) mod N_REQ and takes the first index with i_ReqValid set; last_grant updates at each grant.
REQ-009 Packet lock: if the granted byte had i_ReqLast=0, the lock SHALL be set to g.
- While locked, only port g SHALL be granted; the block SHALL wait in IDLE if i_ReqValid[g]=0.
- The lock SHALL clear when a granted byte has i_ReqLast=1, or on timeout.
REQ-010 In WAIT_START, o_TxValid SHALL stay 1 until i_TxDone is sampled 0; at that edge o_TxValid <= 0 and state <= WAIT_DONE.
REQ-011 WAIT_START SHALL have a 16-bit cycle counter, cleared on entry. When it reaches TIMEOUT with i_TxDone still 1:
- o_Error SHALL pulse for one cycle.
- o_TxValid <= 0, the lock SHALL clear, and state <= IDLE.
REQ-012 In WAIT_DONE, on i_TxDone sampled 1, state SHALL go to IDLE; a new grant SHALL be possible on the next edge (back-to-back during the transmitter stop bit).
REQ-013 o_Grant SHALL hold onehot(g) from the grant edge until the edge leaving WAIT_DONE or timing out, then return to 0.
REQ-014 o_TxByte SHALL hold its last loaded value outside transfers.
REQ-015 i_ReqValid changes outside IDLE SHALL have no effect; deassertion of i_ReqValid before o_ReqReady is a protocol violation and is not required to be detected.

Reset
REQ-016 On i_ResetN low, regardless of state, the block SHALL immediately set:
- state = IDLE.
- o_TxValid = 0, o_TxByte = 8'h00, o_ReqReady = 0, o_Grant = 0, o_Busy = 0, o_Error = 0.
- lock cleared, timeout counter = 0.
- last_grant = N_REQ-1, so port 0 has first priority.
REQ-017 Reset asserted during WAIT_START or WAIT_DONE SHALL drop o_TxValid without an o_ReqReady re-pulse after release.

Verification
REQ-018 Single request: port 2 valid, byte 8'hA5, last=1, i_TxDone toggles 1->0->1 -> o_Grant=4'b0100, o_ReqReady[2] one cycle, o_TxByte=A5, o_TxValid high until i_TxDone=0, o_Busy low after i_TxDone returns 1.
REQ-019 All four ports valid continuously, last=1 -> grants in order 0,1,2,3,0, one per completed transfer.
REQ-020 Packet lock: port 1 sends 3 bytes with last=0,0,1 while port 0 is valid -> port 1 is granted three times consecutively, then port 0.
REQ-021 Timeout: TIMEOUT=8, i_TxDone held 1 -> o_Error pulses once, 8 cycles after entering WAIT_START; o_TxValid=0; back to IDLE.
REQ-022 Reset in WAIT_DONE -> all outputs at reset values immediately; after release with port 3 valid, port 0 priority order resumes and grant goes to port 3.
